vx_dram_arb: RTL and testbench

- Shares one DRAM request/response port among NUM_REQS cache DRAM ports (default 2: icache=0, dcache=1); sits between the per-core caches and the core's single DRAM interface.
- Requests: round-robin arbitration into a one-entry registered output stage.
- Source index is appended to the tag LSBs; responses are routed back by that index.
- Per-source outstanding-read counters throttle requesters at MAX_PENDING.

---
 rtl/vx_dram_arb_pkg.sv | 15 +
 rtl/vx_rr_arbiter.sv | 40 ++++
 rtl/vx_dram_arb.sv | 143 ++++++++++++++
 tb/tb_vx_dram_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dram_arb_pkg.sv
// vx_dram_arb_pkg: shared sizing helpers and source-index constants for the DRAM arbiter
package vx_dram_arb_pkg;

    localparam int SRC_ICACHE = 0;
    localparam int SRC_DCACHE = 1;

    function automatic int dram_arb_sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int dram_arb_tag_out_width(input int tag_in, input int n);
        return tag_in + dram_arb_sel_bits(n);
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter: round-robin arbiter; grants the first request at or after the pointer
module vx_rr_arbiter #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     requests,
    input  logic             enable,
    output logic [SEL_W-1:0] grant_index,
    output logic [N-1:0]     grant_onehot,
    output logic             grant_valid
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cand;

    // scan from the farthest offset down so the nearest request wins
    always_comb begin
        grant_index = ptr;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = SEL_W'((int'(ptr) + k) % N);
            if (requests[cand]) begin
                grant_index = cand;
                grant_valid = enable;
            end
        end
        grant_onehot = grant_valid ? (N'(1) << grant_index) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (grant_valid)
            ptr <= SEL_W'((int'(grant_index) + 1) % N);
    end

endmodule

// File: rtl/vx_dram_arb.sv
// vx_dram_arb: shares one DRAM port among NUM_REQS cache ports with source-tagged
// round-robin requests, tag-routed responses and per-source read throttling.
module vx_dram_arb
    import vx_dram_arb_pkg::*;
#(
    parameter int NUM_REQS      = 2,
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_WIDTH    = 512,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int MAX_PENDING   = 8,
    localparam int REQ_SEL_BITS  = dram_arb_sel_bits(NUM_REQS),
    localparam int TAG_OUT_WIDTH = dram_arb_tag_out_width(TAG_IN_WIDTH, NUM_REQS),
    localparam int CNT_W         = $clog2(MAX_PENDING + 1),
    localparam int BE_W          = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid_in,
    input  logic [NUM_REQS-1:0]              req_rw_in,
    input  logic [NUM_REQS*BE_W-1:0]         req_byteen_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
    output logic [NUM_REQS-1:0]              req_ready_in,
    output logic                             req_valid_out,
    output logic                             req_rw_out,
    output logic [BE_W-1:0]                  req_byteen_out,
    output logic [ADDR_WIDTH-1:0]            req_addr_out,
    output logic [DATA_WIDTH-1:0]            req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
    input  logic                             req_ready_out,
    input  logic                             rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]            rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
    output logic                             rsp_ready_in,
    output logic [NUM_REQS-1:0]              rsp_valid_out,
    output logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_data_out,
    output logic [NUM_REQS*TAG_IN_WIDTH-1:0] rsp_tag_out,
    input  logic [NUM_REQS-1:0]              rsp_ready_out
);

    logic [BE_W-1:0]         byteen_a [NUM_REQS];
    logic [ADDR_WIDTH-1:0]   addr_a   [NUM_REQS];
    logic [DATA_WIDTH-1:0]   data_a   [NUM_REQS];
    logic [TAG_IN_WIDTH-1:0] tag_a    [NUM_REQS];
    logic [CNT_W-1:0]        pend     [NUM_REQS];

    logic [NUM_REQS-1:0]     eligible;
    logic [NUM_REQS-1:0]     rd_hs;
    logic [NUM_REQS-1:0]     rsp_hs;
    logic [REQ_SEL_BITS-1:0] grant_index;
    logic [REQ_SEL_BITS-1:0] sel;
    logic                    grant_valid;
    logic                    stage_load;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
        assign byteen_a[i] = req_byteen_in[i*BE_W +: BE_W];
        assign addr_a[i]   = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[i]   = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        assign tag_a[i]    = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
    end

    // writes never return a response, so only reads count against the budget
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++)
            eligible[i] = req_valid_in[i] && (req_rw_in[i] || pend[i] < CNT_W'(MAX_PENDING));
    end

    assign stage_load = !req_valid_out || req_ready_out;

    vx_rr_arbiter #(
        .N     (NUM_REQS),
        .SEL_W (REQ_SEL_BITS)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (eligible),
        .enable       (stage_load),
        .grant_index  (grant_index),
        .grant_onehot (req_ready_in),
        .grant_valid  (grant_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_valid_out  <= 1'b0;
            req_rw_out     <= 1'b0;
            req_byteen_out <= '0;
            req_addr_out   <= '0;
            req_data_out   <= '0;
            req_tag_out    <= '0;
        end else if (grant_valid) begin
            req_valid_out  <= 1'b1;
            req_rw_out     <= req_rw_in[grant_index];
            req_byteen_out <= byteen_a[grant_index];
            req_addr_out   <= addr_a[grant_index];
            req_data_out   <= data_a[grant_index];
            req_tag_out    <= {tag_a[grant_index], grant_index};
        end else if (req_ready_out) begin
            req_valid_out  <= 1'b0;
        end
    end

    assign sel = rsp_tag_in[REQ_SEL_BITS-1:0];

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++)
            rsp_valid_out[i] = rsp_valid_in && (sel == REQ_SEL_BITS'(i));
    end

    // an out-of-range source is accepted and dropped so the DRAM side never stalls
    assign rsp_ready_in = (int'(sel) < NUM_REQS) ? rsp_ready_out[sel] : 1'b1;
    assign rsp_data_out = {NUM_REQS{rsp_data_in}};
    assign rsp_tag_out  = {NUM_REQS{rsp_tag_in[TAG_OUT_WIDTH-1:REQ_SEL_BITS]}};

    assign rd_hs  = req_ready_in & req_valid_in & ~req_rw_in;
    assign rsp_hs = rsp_valid_out & rsp_ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++)
                pend[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (rd_hs[i] && !rsp_hs[i])
                    pend[i] <= pend[i] + CNT_W'(1);
                else if (rsp_hs[i] && !rd_hs[i])
                    pend[i] <= pend[i] - CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (reset)
            pend[i] <= CNT_W'(MAX_PENDING));
        a_no_underflow: assert property (@(posedge clk) disable iff (reset)
            !(rsp_hs[i] && pend[i] == '0));
    end

    a_rsp_sel_range: assert property (@(posedge clk) disable iff (reset)
        !(rsp_valid_in && int'(sel) >= NUM_REQS));

endmodule

// File: tb/tb_vx_dram_arb.sv
// tb_vx_dram_arb: directed scoreboard bench; stimulus pushes expected DRAM requests,
// a negedge monitor pops and compares them on each output handshake.
module tb_vx_dram_arb;

    typedef struct {
        logic         rw;
        logic [25:0]  addr;
        logic [8:0]   tag;
        logic [63:0]  be;
        logic [511:0] data;
    } req_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    vin, rwv;
    logic [25:0]   ad [2];
    logic [7:0]    tg [2];
    logic [1:0]    req_ready_in;
    logic          req_valid_out, req_rw_out;
    logic [63:0]   req_byteen_out;
    logic [25:0]   req_addr_out;
    logic [511:0]  req_data_out;
    logic [8:0]    req_tag_out;
    logic          req_ready_out;
    logic          rsp_valid_in;
    logic [511:0]  rsp_data_in;
    logic [8:0]    rsp_tag_in;
    logic          rsp_ready_in;
    logic [1:0]    rsp_valid_out;
    logic [1023:0] rsp_data_out;
    logic [15:0]   rsp_tag_out;
    logic [1:0]    rsp_ready_out;

    int   errors = 0;
    int   checks = 0;
    req_t sb [$];

    function automatic logic [511:0] fd(input logic [25:0] a);
        return {16{6'b0, a}};
    endfunction

    function automatic logic [63:0] fb(input logic [7:0] t);
        return {8{t}};
    endfunction

    always #5 clk = ~clk;

    vx_dram_arb dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_in   (vin),
        .req_rw_in      (rwv),
        .req_byteen_in  ({fb(tg[1]), fb(tg[0])}),
        .req_addr_in    ({ad[1], ad[0]}),
        .req_data_in    ({fd(ad[1]), fd(ad[0])}),
        .req_tag_in     ({tg[1], tg[0]}),
        .req_ready_in   (req_ready_in),
        .req_valid_out  (req_valid_out),
        .req_rw_out     (req_rw_out),
        .req_byteen_out (req_byteen_out),
        .req_addr_out   (req_addr_out),
        .req_data_out   (req_data_out),
        .req_tag_out    (req_tag_out),
        .req_ready_out  (req_ready_out),
        .rsp_valid_in   (rsp_valid_in),
        .rsp_data_in    (rsp_data_in),
        .rsp_tag_in     (rsp_tag_in),
        .rsp_ready_in   (rsp_ready_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_data_out   (rsp_data_out),
        .rsp_tag_out    (rsp_tag_out),
        .rsp_ready_out  (rsp_ready_out)
    );

    task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] rw, input logic [25:0] a0,
                       input logic [25:0] a1, input logic [7:0] t0, input logic [7:0] t1);
        vin   = v;
        rwv   = rw;
        ad[0] = a0;
        ad[1] = a1;
        tg[0] = t0;
        tg[1] = t1;
    endtask

    // check the expected grant, queue the expected request, then confirm 1-cycle latency
    task automatic step(input logic [1:0] exp, input string nm);
        req_t e;
        logic g;
        #1;
        chk(64'(req_ready_in), 64'(exp), {nm, "_ready"});
        g = exp[1];
        if (exp != 2'b00) begin
            e.rw   = rwv[g];
            e.addr = ad[g];
            e.tag  = {tg[g], g};
            e.be   = fb(tg[g]);
            e.data = fd(ad[g]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp != 2'b00) begin
            chk(64'(req_valid_out), 64'd1, {nm, "_vout"});
            chk(64'(req_addr_out), 64'(e.addr), {nm, "_lat_addr"});
        end
    endtask

    always @(negedge clk) begin
        if (!reset && req_valid_out && req_ready_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got a=%h t=%h expected no request", req_addr_out, req_tag_out);
            end else begin
                req_t e;
                e = sb.pop_front();
                if ({req_rw_out, req_addr_out, req_tag_out, req_byteen_out, req_data_out} !==
                    {e.rw, e.addr, e.tag, e.be, e.data}) begin
                    errors++;
                    $display("FAIL mon_req: got rw=%b a=%h t=%h be=%h d=%h expected rw=%b a=%h t=%h be=%h d=%h",
                             req_rw_out, req_addr_out, req_tag_out, req_byteen_out, req_data_out[63:0],
                             e.rw, e.addr, e.tag, e.be, e.data[63:0]);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        req_ready_out = 1'b1;
        rsp_valid_in  = 1'b0;
        rsp_data_in   = '0;
        rsp_tag_in    = '0;
        rsp_ready_out = 2'b00;
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk(64'(req_valid_out), 64'd0, "rst_vout");
        chk(64'(req_tag_out), 64'd0, "rst_tag");
        chk(64'(req_addr_out), 64'd0, "rst_addr");
        chk(req_data_out[63:0], 64'd0, "rst_data");
        reset = 1'b0;
        step(2'b00, "idle");

        // both sources stream reads: grants alternate starting at source 0
        for (int k = 0; k < 4; k++) begin
            drv(2'b11, 2'b00, 26'h100 + 26'(k), 26'h200 + 26'(k), 8'h10 + 8'(k), 8'h20 + 8'(k));
            step(k[0] ? 2'b10 : 2'b01, "rr");
        end
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        step(2'b00, "rr_drain");

        // backpressure: first request captured, held for 5 cycles, next issues after release
        req_ready_out = 1'b0;
        drv(2'b10, 2'b00, 0, 26'h300, 0, 8'h33);
        step(2'b10, "bp_cap");
        drv(2'b10, 2'b00, 0, 26'h301, 0, 8'h34);
        for (int k = 0; k < 5; k++) begin
            step(2'b00, "bp_hold");
            chk(64'(req_valid_out), 64'd1, "bp_vout");
            chk(64'(req_addr_out), 64'h300, "bp_addr");
            chk(64'(req_tag_out), 64'({8'h33, 1'b1}), "bp_tag");
        end
        req_ready_out = 1'b1;
        step(2'b10, "bp_next");
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        step(2'b00, "bp_drain");

        // asynchronous reset with a request sitting in the output stage
        drv(2'b11, 2'b00, 26'h400, 26'h500, 8'h40, 8'h50);
        step(2'b01, "pre_rst");
        #2;
        reset = 1'b1;
        #1;
        chk(64'(req_valid_out), 64'd0, "rst_async");
        sb.delete();
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        drv(2'b11, 2'b00, 26'h600, 26'h700, 8'h60, 8'h70);
        step(2'b01, "rst_first");

        // fill source 0 to 8 outstanding reads
        for (int k = 0; k < 7; k++) begin
            drv(2'b01, 2'b00, 26'h800 + 26'(k), 0, 8'h80 + 8'(k), 0);
            step(2'b01, "thr_fill");
        end
        drv(2'b11, 2'b00, 26'h900, 26'hA00, 8'h90, 8'hA0);
        step(2'b10, "thr_block");
        drv(2'b11, 2'b01, 26'h901, 26'hA01, 8'h91, 8'hA1);
        step(2'b01, "thr_wr");
        drv(2'b11, 2'b00, 26'h902, 26'hA02, 8'h92, 8'hA2);
        step(2'b10, "thr_s1");
        drv(2'b01, 2'b00, 26'h903, 0, 8'h93, 0);
        step(2'b00, "thr_rd0");

        // one response to source 0 frees a slot for the following cycle
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {8'h11, 1'b0};
        rsp_data_in   = fd(26'h55);
        rsp_ready_out = 2'b01;
        drv(2'b01, 2'b00, 26'h904, 0, 8'h94, 0);
        #1;
        chk(64'(rsp_valid_out), 64'b01, "thr_rsp_vout");
        chk(64'(rsp_ready_in), 64'd1, "thr_rsp_rdy");
        step(2'b00, "thr_rsp_blk");
        rsp_valid_in = 1'b0;
        step(2'b01, "thr_reen");

        // boundary: response at 8 frees one, simultaneous read+response holds the count
        rsp_valid_in = 1'b1;
        rsp_tag_in   = {8'h12, 1'b0};
        drv(2'b01, 2'b00, 26'h905, 0, 8'h95, 0);
        step(2'b00, "bnd_blk");
        drv(2'b01, 2'b00, 26'h906, 0, 8'h96, 0);
        step(2'b01, "bnd_both");
        rsp_valid_in = 1'b0;
        drv(2'b01, 2'b00, 26'h907, 0, 8'h97, 0);
        step(2'b01, "bnd_fill");
        drv(2'b01, 2'b00, 26'h908, 0, 8'h98, 0);
        step(2'b00, "bnd_full");

        // response routing to source 1 waits for its ready
        drv(2'b00, 2'b00, 0, 0, 0, 0);
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {8'hA5, 1'b1};
        rsp_data_in   = fd(26'h123);
        rsp_ready_out = 2'b01;
        #1;
        chk(64'(rsp_valid_out), 64'b10, "rt_vout");
        chk(64'(rsp_tag_out), 64'hA5A5, "rt_tag");
        chk(64'(rsp_ready_in), 64'd0, "rt_rdy_wait");
        chk(rsp_data_out[575:512], fd(26'h123) & 64'hFFFF_FFFF_FFFF_FFFF, "rt_data1");
        chk(rsp_data_out[63:0], fd(26'h123) & 64'hFFFF_FFFF_FFFF_FFFF, "rt_data0");
        step(2'b00, "rt_wait");
        chk(64'(rsp_ready_in), 64'd0, "rt_rdy_hold");
        rsp_ready_out = 2'b11;
        #1;
        chk(64'(rsp_ready_in), 64'd1, "rt_rdy_go");
        step(2'b00, "rt_hs");
        rsp_valid_in = 1'b0;
        #1;
        chk(64'(rsp_valid_out), 64'b00, "rt_idle");

        repeat (3) step(2'b00, "end");
        chk(64'(sb.size()), 64'd0, "sb_empty");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
